// File: rtl/tdc_interval_sensor.sv
// Multi-channel time-interval sensor: measures start->stop edge intervals on a selected
// channel, averages 2^AVG_LOG2 samples and reports a saturated result.
// Optional min/max sample tracking is enabled with `define TDC_MINMAX_EN.
module tdc_interval_sensor #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned SW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SW-1:0]       ch_sel,
  input  logic                start_req,
  input  logic [CHANNELS-1:0] start_in,
  input  logic [CHANNELS-1:0] stop_in,
  output logic                busy,
  output logic                valid,
  output logic [OUT_W-1:0]    count_out,
`ifdef TDC_MINMAX_EN
  output logic [OUT_W-1:0]    min_out,
  output logic [OUT_W-1:0]    max_out,
`endif
  output logic                overflow
);

  localparam int unsigned SUM_W = CNT_W + AVG_LOG2;
  localparam int unsigned IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] OUT_MAX  = CNT_W'({OUT_W{1'b1}});
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [OUT_W-1:0] sat_out(input logic [CNT_W-1:0] v);
    return (v > OUT_MAX) ? {OUT_W{1'b1}} : v[OUT_W-1:0];
  endfunction

  // Synchroniser chains: stage 0 samples the pin, stage SYNC_STAGES-1 feeds edge detection.
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] start_sync_q, start_sync_d;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] stop_sync_q, stop_sync_d;
  logic [CHANNELS-1:0]                  start_prev_q, start_prev_d;
  logic [CHANNELS-1:0]                  stop_prev_q, stop_prev_d;

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    ch_q, ch_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_ovf_q, run_ovf_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] count_out_q, count_out_d;
  logic             overflow_q, overflow_d;

`ifdef TDC_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [OUT_W-1:0] min_out_q, min_out_d;
  logic [OUT_W-1:0] max_out_q, max_out_d;
`endif

  logic [CHANNELS-1:0] start_edge_c, stop_edge_c;
  logic                start_hit_c, stop_hit_c;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic                sample_done;
  logic [CNT_W-1:0]    sample_val;
  logic                sample_ovf;
  logic [CNT_W-1:0]    avg;

  assign start_edge_c = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
  assign stop_edge_c  = stop_sync_q[SYNC_STAGES-1] & ~stop_prev_q;
  assign start_hit_c  = start_edge_c[ch_q];
  assign stop_hit_c   = stop_edge_c[ch_q];
  assign cnt_inc_c    = cnt_q + CNT_W'(1);

  always_comb begin
    start_sync_d = {start_sync_q[SYNC_STAGES-2:0], start_in};
    stop_sync_d  = {stop_sync_q[SYNC_STAGES-2:0], stop_in};
    start_prev_d = start_sync_q[SYNC_STAGES-1];
    stop_prev_d  = stop_sync_q[SYNC_STAGES-1];
  end

  // Measurement FSM; the result is computed on the final sample so it lands in the DONE cycle.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    run_ovf_d   = run_ovf_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    count_out_d = count_out_q;
    overflow_d  = overflow_q;
    sample_done = 1'b0;
    sample_val  = '0;
    sample_ovf  = 1'b0;
    avg         = '0;
`ifdef TDC_MINMAX_EN
    min_d       = min_q;
    max_d       = max_q;
    min_out_d   = min_out_q;
    max_out_d   = max_out_q;
`endif

    case (state_q)
      S_IDLE: begin
        idx_d     = '0;
        sum_d     = '0;
        run_ovf_d = 1'b0;
        cnt_d     = '0;
        if (start_req) begin
          ch_d    = (32'(ch_sel) < CHANNELS) ? ch_sel : '0;
          busy_d  = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (start_hit_c) begin
          if (stop_hit_c) begin
            sample_done = 1'b1;
            sample_val  = '0;
          end else begin
            cnt_d   = '0;
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        // cnt_q holds k-1 in the k-th cycle after the start edge.
        if (stop_hit_c) begin
          sample_done = 1'b1;
          sample_val  = cnt_inc_c;
        end else if (cnt_inc_c == CNT_MAX) begin
          sample_done = 1'b1;
          sample_val  = CNT_MAX;
          sample_ovf  = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (sample_done) begin
      sum_d     = sum_q + SUM_W'(sample_val);
      run_ovf_d = run_ovf_q | sample_ovf;
`ifdef TDC_MINMAX_EN
      if (idx_q == '0) begin
        min_d = sample_val;
        max_d = sample_val;
      end else begin
        if (sample_val < min_q) min_d = sample_val;
        if (sample_val > max_q) max_d = sample_val;
      end
`endif
      if (idx_q == IDX_LAST) begin
        avg         = CNT_W'(sum_d >> AVG_LOG2);
        count_out_d = sat_out(avg);
        overflow_d  = run_ovf_d | (avg > OUT_MAX);
        valid_d     = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_DONE;
`ifdef TDC_MINMAX_EN
        min_out_d   = sat_out(min_d);
        max_out_d   = sat_out(max_d);
`endif
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = S_ARM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
      start_prev_q <= '0;
      stop_prev_q  <= '0;
      state_q      <= S_IDLE;
      ch_q         <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      run_ovf_q    <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      count_out_q  <= '0;
      overflow_q   <= 1'b0;
`ifdef TDC_MINMAX_EN
      min_q        <= '0;
      max_q        <= '0;
      min_out_q    <= '0;
      max_out_q    <= '0;
`endif
    end else begin
      start_sync_q <= start_sync_d;
      stop_sync_q  <= stop_sync_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      state_q      <= state_d;
      ch_q         <= ch_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      run_ovf_q    <= run_ovf_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      count_out_q  <= count_out_d;
      overflow_q   <= overflow_d;
`ifdef TDC_MINMAX_EN
      min_q        <= min_d;
      max_q        <= max_d;
      min_out_q    <= min_out_d;
      max_out_q    <= max_out_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign count_out = count_out_q;
  assign overflow  = overflow_q;
`ifdef TDC_MINMAX_EN
  assign min_out   = min_out_q;
  assign max_out   = max_out_q;
`endif

endmodule

// File: tb/tb_tdc_interval_sensor.sv
// Directed bench for tdc_interval_sensor (default parameters); checks result, flags and
// pulse count for each run, plus min/max when TDC_MINMAX_EN is defined.
module tb_tdc_interval_sensor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ch_sel;
  logic       start_req;
  logic [3:0] start_in;
  logic [3:0] stop_in;
  logic       busy;
  logic       valid;
  logic [7:0] count_out;
  logic       overflow;
`ifdef TDC_MINMAX_EN
  logic [7:0] min_out;
  logic [7:0] max_out;
`endif

  int total = 0;
  int bad   = 0;

  int         vcnt = 0;
  logic [7:0] last_cnt;
  logic       last_ovf;
  logic       last_busy;
`ifdef TDC_MINMAX_EN
  logic [7:0] last_min;
  logic [7:0] last_max;
`endif

  tdc_interval_sensor u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_sel    (ch_sel),
    .start_req (start_req),
    .start_in  (start_in),
    .stop_in   (stop_in),
    .busy      (busy),
    .valid     (valid),
    .count_out (count_out),
`ifdef TDC_MINMAX_EN
    .min_out   (min_out),
    .max_out   (max_out),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Capture every result pulse mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      vcnt      <= vcnt + 1;
      last_cnt  <= count_out;
      last_ovf  <= overflow;
      last_busy <= busy;
`ifdef TDC_MINMAX_EN
      last_min  <= min_out;
      last_max  <= max_out;
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] ch);
    ch_sel    = ch;
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
  endtask

  task automatic meas(input int ch, input int k);
    if (k == 0) begin
      start_in[ch] = 1'b1;
      stop_in[ch]  = 1'b1;
    end else begin
      start_in[ch] = 1'b1;
      tick(k);
      stop_in[ch]  = 1'b1;
    end
    tick(3);
    start_in[ch] = 1'b0;
    stop_in[ch]  = 1'b0;
    tick(3);
  endtask

  task automatic wait_valid(input string tag, input int exp);
    for (int i = 0; i < 50 && vcnt < exp; i++) tick(1);
    chk(tag, vcnt, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    ch_sel    = '0;
    start_req = 1'b0;
    start_in  = '0;
    stop_in   = '0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", count_out, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    tick(2);

    // ch1, all intervals 10
    start_run(2'd1);
    chk("t1_busy_up", busy, 1);
    for (int s = 0; s < 4; s++) meas(1, 10);
    wait_valid("t1_vcnt", 1);
    chk("t1_count", last_cnt, 10);
    chk("t1_ovf", last_ovf, 0);
    chk("t1_busy_in_valid", last_busy, 0);
    chk("t1_busy_after", busy, 0);

    // ch2, 8/10/12/14 -> 44>>2
    start_run(2'd2);
    meas(2, 8);
    meas(2, 10);
    meas(2, 12);
    meas(2, 14);
    wait_valid("t2_vcnt", 2);
    chk("t2_count", last_cnt, 11);
    chk("t2_ovf", last_ovf, 0);
`ifdef TDC_MINMAX_EN
    chk("t2_min", last_min, 8);
    chk("t2_max", last_max, 14);
`endif

    // ch0, no stop: every sample saturates at 4095
    start_run(2'd0);
    for (int s = 0; s < 4; s++) begin
      start_in[0] = 1'b1;
      tick(4200);
      start_in[0] = 1'b0;
      tick(3);
    end
    wait_valid("t3_vcnt", 3);
    chk("t3_count", last_cnt, 255);
    chk("t3_ovf", last_ovf, 1);
    start_run(2'd0);
    for (int s = 0; s < 4; s++) meas(0, 3);
    wait_valid("t3b_vcnt", 4);
    chk("t3b_count", last_cnt, 3);
    chk("t3b_ovf", last_ovf, 0);

    // coincident start/stop edges, plus an extra request mid-run
    start_run(2'd1);
    meas(1, 0);
    meas(1, 0);
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
    meas(1, 0);
    meas(1, 0);
    wait_valid("t4_vcnt", 5);
    chk("t4_count", last_cnt, 0);
    tick(30);
    chk("t4_no_extra_valid", vcnt, 5);
    chk("t4_idle", busy, 0);

    // ch3 selected, ch0 carries conflicting traffic
    start_run(2'd3);
    for (int s = 0; s < 4; s++) begin
      start_in[3] = 1'b1;
      start_in[0] = 1'b1;
      tick(5);
      stop_in[0]  = 1'b1;
      tick(15);
      stop_in[3]  = 1'b1;
      tick(3);
      start_in = '0;
      stop_in  = '0;
      tick(3);
    end
    wait_valid("t5_vcnt", 6);
    chk("t5_count", last_cnt, 20);

    // ch_sel changes mid-run: ch1 stays measured
    start_run(2'd1);
    ch_sel = 2'd3;
    for (int s = 0; s < 4; s++) meas(1, 6);
    wait_valid("t6_vcnt", 7);
    chk("t6_count", last_cnt, 6);

    // reset during COUNT after one completed sample
    start_run(2'd0);
    meas(0, 7);
    start_in[0] = 1'b1;
    tick(10);
    rst_n = 1'b0;
    #1;
    chk("t7_busy_rst", busy, 0);
    chk("t7_count_rst", count_out, 0);
    chk("t7_valid_rst", valid, 0);
    start_in = '0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("t7_no_partial", vcnt, 7);
    start_run(2'd0);
    for (int s = 0; s < 4; s++) meas(0, 5);
    wait_valid("t7_vcnt", 8);
    chk("t7_count", last_cnt, 5);
    chk("t7_ovf", last_ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
